// File: rtl/reg_dump.sv
// Register-file dump engine: walks registers 0..NUM_REGS-1 through one read port
// and streams the captured values over valid/ready. Optional macro: REG_DUMP_CHECKSUM_EN.
module reg_dump #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_sel,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_CSUM, S_FIN} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_FIN} state_e;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   idx_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [ADDR_WIDTH-1:0]   out_idx_q;
    logic                    out_last_q;
    logic                    done_q;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   acc_q;
`endif

    assign idx_d = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        acc_q   <= '0;
`endif
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Snapshot the register so later regfile writes cannot disturb the beat.
                    out_data_q  <= rd_data;
                    out_idx_q   <= idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last_q  <= 1'b0;
                    acc_q       <= acc_q ^ rd_data;
`else
                    out_last_q  <= (idx_q == LAST_IDX);
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // out_valid stays high straight into the checksum beat.
                            out_data_q  <= acc_q;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b1;
                            state_q     <= S_CSUM;
`else
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_FIN;
`endif
                        end else begin
                            idx_q       <= idx_d;
                            out_valid_q <= 1'b0;
                            state_q     <= S_LOAD;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_sel    = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
